reg_bank: RTL
=============

# reg_bank

Parametrised bank of NREGS general-purpose registers, each WIDTH bits, with one addressed write/modify port and two asynchronous read ports. Extends the single loadable register with multiple registers, increment/decrement/clear modes, and registered carry and zero flags. Sits in the CPU datapath as the register file feeding the ALU operand buses.

## Interface

- WIDTH, 4, bits per register (≥1)
- NREGS, 4, number of registers (≥2)
- AW, 2, address width; must satisfy 2^AW ≥ NREGS
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; overrides every other input
- load_n  input  1  write strobe, active-low; high = all state holds
- op  input  2  operation applied to reg[waddr] when load_n low
- waddr  input  AW  target register for op
- data  input  WIDTH  load value for op 00
- raddr_a  input  AW  read port A address
- raddr_b  input  AW  read port B address
- dout_a  output  WIDTH  reg[raddr_a], combinational
- dout_b  output  WIDTH  reg[raddr_b], combinational
- carry  output  1  registered carry/borrow flag
- zero  output  1  registered: last written result was zero

## Operation

- reset high at rising edge: every register ← 0, carry ← 0, zero ← 1. Reset asserted mid-sequence discards any concurrent load_n/op.
- load_n high: no register or flag changes regardless of op/waddr/data.
- load_n low, waddr < NREGS, op decoded as:
  - 00 LOAD: reg ← data; carry ← 0
  - 01 INC: reg ← reg + 1 mod 2^WIDTH; carry ← 1 iff old value was all-ones (wrap to 0), else 0
  - 10 DEC: reg ← reg − 1 mod 2^WIDTH; carry ← 1 iff old value was 0 (wrap to all-ones), else 0
  - 11 CLR: reg ← 0; carry ← 0
  - zero ← 1 iff the new register value is 0
- load_n low, waddr ≥ NREGS (non-power-of-2 NREGS): write ignored; registers, carry, zero unchanged.
- Only reg[waddr] changes on a write; all others hold.
- Reads: dout_a/dout_b combinational from the array; raddr ≥ NREGS returns 0. Both ports may address the same register, including the one being written.
- Arithmetic strictly WIDTH bits; no sign interpretation.

## Timing

- Write latency: new value visible on dout_a/dout_b immediately after the rising edge that samples load_n low; carry/zero update on the same edge.
- No write-through bypass: during the cycle load_n is low, a read of waddr returns the old value until the edge.
- Read latency: zero cycles (address change → output change combinationally).
- load_n held low over consecutive edges applies op once per edge (e.g. INC held 3 cycles adds 3).
- Flags reflect only the most recent effective write; they hold through idle cycles.
- Outputs after reset: all dout = 0, carry = 0, zero = 1.

## Test plan

- Reset then read: reset high one edge; raddr_a=0..3 → dout_a=0 each, carry=0, zero=1.
- Load and independence: load_n low, op=00, waddr=1, data=4'h2, one edge; then waddr=2, data=4'h5 → dout_a(raddr 1)=2, dout_b(raddr 2)=5, reg0/reg3 = 0, zero=0.
- Increment wrap: load reg3=4'hE; INC held low two edges → reg3=F (carry 0) then 0 with carry=1, zero=1; one further idle cycle → carry, zero hold.
- Decrement borrow: reg0=0, DEC one edge → reg0=F, carry=1, zero=0; LOAD data=4'h0 → carry=0, zero=1.
- No bypass / hold: set load_n low, waddr=1, op=00, data=4'h9 with raddr_a=1 → dout_a=2 before edge, 9 after; load_n high with changing op/data → nothing changes.
- Reset mid-operation: reset and load_n low (INC on reg1=9) same edge → all registers 0, carry=0, zero=1; NREGS=3 build: write to waddr=3 ignored, read of 3 returns 0.

Source files
------------

// File: rtl/reg_bank_if.sv
// Port bundle for reg_bank: write/modify strobe, two read ports and status flags.
// The master drives commands and addresses; the slave (the register bank) answers.
interface reg_bank_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 2
);
  logic             load_n;
  logic [1:0]       op;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] data;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] dout_a;
  logic [WIDTH-1:0] dout_b;
  logic             carry;
  logic             zero;

  modport master (
    output load_n, op, waddr, data, raddr_a, raddr_b,
    input  dout_a, dout_b, carry, zero
  );

  modport slave (
    input  load_n, op, waddr, data, raddr_a, raddr_b,
    output dout_a, dout_b, carry, zero
  );
endinterface

// File: rtl/reg_bank.sv
// Register file of NREGS x WIDTH with one LOAD/INC/DEC/CLR write port,
// two combinational read ports, and registered carry/zero flags.
module reg_bank #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input logic        clk,
  input logic        reset,
  reg_bank_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             waddr_ok;
  logic             wr_en;
  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] wr_val;

  // Out-of-range write addresses (non-power-of-2 NREGS) are silently dropped.
  always_comb begin
    waddr_ok = (int'(bus.waddr) < NREGS);
    wr_en    = !bus.load_n && waddr_ok;
    old_val  = '0;
    if (waddr_ok) begin
      old_val = regs_q[bus.waddr];
    end
    wr_val  = old_val;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (wr_en) begin
      case (bus.op)
        2'b00: begin
          wr_val  = bus.data;
          carry_d = 1'b0;
        end
        2'b01: begin
          wr_val  = old_val + ONE;
          carry_d = (old_val == ALL_ONES);
        end
        2'b10: begin
          wr_val  = old_val - ONE;
          carry_d = (old_val == '0);
        end
        default: begin
          wr_val  = '0;
          carry_d = 1'b0;
        end
      endcase
      zero_d = (wr_val == '0);
    end
  end

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_q[gi] <= '0;
        end else if (wr_en && (bus.waddr == AW'(gi))) begin
          regs_q[gi] <= wr_val;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Reads see the array directly, so a write is only visible after its edge.
  always_comb begin
    bus.dout_a = '0;
    bus.dout_b = '0;
    if (int'(bus.raddr_a) < NREGS) begin
      bus.dout_a = regs_q[bus.raddr_a];
    end
    if (int'(bus.raddr_b) < NREGS) begin
      bus.dout_b = regs_q[bus.raddr_b];
    end
  end

  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;

endmodule
